// File: rtl/cim_pkg.sv
// cim_seq shared types: FSM states, walk mode and flip-group index helper.
// Optional circular mode is compiled in with CIM_SEQ_CIRCULAR_EN.
package cim_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_STEP = 2'd1;
    localparam state_t S_DONE = 2'd2;

    typedef enum logic {
        CIM_LINEAR   = 1'b0,
        CIM_CIRCULAR = 1'b1
    } mode_e;

    // Group flipped by one step away from lvl; circular levels fold onto N/2 groups.
    function automatic int unsigned group_idx(
        input int unsigned lvl,
        input logic        up,
        input logic        circ,
        input int unsigned n
    );
        int unsigned src;
        src = up ? lvl : ((lvl == 0) ? n - 1 : lvl - 1);
        return circ ? src % (n / 2) : src;
    endfunction

endpackage

// File: rtl/ca90_hier_base.sv
// Hierarchical CA90 expansion of a seed into a full-width base hypervector.
// Each stage appends the rule-90 image of everything generated so far.
module ca90_hier_base #(
    parameter int HVDimension = 512,
    parameter int SeedWidth   = 32
) (
    input  logic [SeedWidth-1:0]   seed,
    output logic [HVDimension-1:0] base
);

    localparam int Stages = $clog2(HVDimension / SeedWidth);

    function automatic logic [HVDimension-1:0] expand(
        input logic [SeedWidth-1:0] s
    );
        logic [HVDimension-1:0] hv;
        int w;
        hv = '0;
        hv[SeedWidth-1:0] = s;
        for (int k = 0; k < Stages; k++) begin
            w = SeedWidth << k;
            for (int i = 0; i < w; i++) begin
                if (w + i < HVDimension) begin
                    hv[w + i] = hv[(i + 1) % w] ^ hv[(i + w - 1) % w];
                end
            end
        end
        return hv;
    endfunction

    assign base = expand(seed);

endmodule

// File: rtl/cim_group_mask.sv
// Flip mask for one level group: F odd bit positions starting at 2*g*F+1.
// Purely combinational; positions past the HV width are dropped.
module cim_group_mask #(
    parameter int HVDimension   = 512,
    parameter int FlipsPerLevel = 4,
    parameter int LevelWidth    = 6
) (
    input  logic [LevelWidth-1:0]  group,
    output logic [HVDimension-1:0] mask
);

    int pos;

    always_comb begin
        mask = '0;
        pos  = 0;
        for (int j = 0; j < FlipsPerLevel; j++) begin
            pos = 2 * (32'(group) * FlipsPerLevel + j) + 1;
            if (pos < HVDimension) begin
                mask[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cim_seq.sv
// Sequential continuous item memory: walks one HV register level-by-level.
// Define CIM_SEQ_CIRCULAR_EN to build the circular (wrap-around) level mode.
module cim_seq
    import cim_pkg::*;
#(
    parameter int HVDimension   = 512,
    parameter int SeedWidth     = 32,
    parameter int NumCimLevels  = 64,
    parameter int FlipsPerLevel = 4,
    parameter int LevelWidth    = $clog2(NumCimLevels)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [SeedWidth-1:0]   seed_hv_i,
    input  logic                   seed_valid_i,
    output logic                   seed_ready_o,
    input  logic                   mode_i,
    input  logic [LevelWidth-1:0]  req_level_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [HVDimension-1:0] cim_o,
    output logic [LevelWidth-1:0]  level_o
);

`ifdef CIM_SEQ_CIRCULAR_EN
    localparam logic CircEn = 1'b1;
`else
    localparam logic CircEn = 1'b0;
`endif

    localparam logic [LevelWidth-1:0] LMax = LevelWidth'(NumCimLevels - 1);

    state_t                 state;
    mode_e                  mode;
    mode_e                  mode_in;
    logic [HVDimension-1:0] cim;
    logic [HVDimension-1:0] seed_base;
    logic [HVDimension-1:0] mask;
    logic [LevelWidth-1:0]  level;
    logic [LevelWidth-1:0]  target;
    logic [LevelWidth-1:0]  tgt;
    logic [LevelWidth-1:0]  lvl_next;
    logic [LevelWidth-1:0]  grp;
    logic                   up;
    logic                   dir_up;
    logic                   idle;

    ca90_hier_base #(
        .HVDimension (HVDimension),
        .SeedWidth   (SeedWidth)
    ) u_base (
        .seed (seed_hv_i),
        .base (seed_base)
    );

    cim_group_mask #(
        .HVDimension   (HVDimension),
        .FlipsPerLevel (FlipsPerLevel),
        .LevelWidth    (LevelWidth)
    ) u_mask (
        .group (grp),
        .mask  (mask)
    );

    assign idle         = (state == S_IDLE);
    assign seed_ready_o = idle;
    // A seed on the same cycle takes priority, so the request is not taken.
    assign req_ready_o  = idle && !seed_valid_i;
    assign rsp_valid_o  = (state == S_DONE);
    assign cim_o        = cim;
    assign level_o      = level;
    assign mode_in      = (mode_i & CircEn) ? CIM_CIRCULAR : CIM_LINEAR;

    assign grp = LevelWidth'(group_idx(32'(level), up,
                                       mode == CIM_CIRCULAR,
                                       NumCimLevels));

    always_comb begin
        if (up) begin
            lvl_next = (level == LMax) ? '0 : level + 1'b1;
        end else begin
            lvl_next = (level == '0) ? LMax : level - 1'b1;
        end
    end

`ifdef CIM_SEQ_CIRCULAR_EN
    int unsigned up_dist;
    int unsigned dn_dist;
`endif

    always_comb begin
        tgt = LMax;
        if (32'(req_level_i) < NumCimLevels) begin
            tgt = req_level_i;
        end
`ifdef CIM_SEQ_CIRCULAR_EN
        up_dist = (32'(tgt) + NumCimLevels - 32'(level)) % NumCimLevels;
        dn_dist = (32'(level) + NumCimLevels - 32'(tgt)) % NumCimLevels;
        if (mode == CIM_CIRCULAR) begin
            dir_up = (up_dist <= dn_dist);
        end else begin
            dir_up = (tgt > level);
        end
`else
        dir_up = (tgt > level);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            mode   <= CIM_LINEAR;
            cim    <= '0;
            level  <= '0;
            target <= '0;
            up     <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (seed_valid_i) begin
                        cim   <= seed_base;
                        level <= '0;
                        mode  <= mode_in;
                    end else if (req_valid_i) begin
                        target <= tgt;
                        up     <= dir_up;
                        state  <= (tgt == level) ? S_DONE : S_STEP;
                    end
                end
                S_STEP: begin
                    cim   <= cim ^ mask;
                    level <= lvl_next;
                    if (lvl_next == target) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_seq.sv
// Self-checking bench for cim_seq: scoreboard of level requests against a
// reference CA90 base and flip-group model; a second instance covers clamping.
module tb_cim_seq;

    localparam int D  = 512;
    localparam int SW = 32;
    localparam int N  = 64;
    localparam int NC = 40;
    localparam int F  = 4;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] seed;
    logic          seed_valid;
    logic          seed_ready;
    logic          mode;
    logic [LW-1:0] req_level;
    logic          req_valid;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [D-1:0]  cim;
    logic [LW-1:0] level;

    logic          c_seed_valid;
    logic          c_seed_ready;
    logic [LW-1:0] c_req_level;
    logic          c_req_valid;
    logic          c_req_ready;
    logic          c_rsp_valid;
    logic          c_rsp_ready;
    logic [D-1:0]  c_cim;
    logic [LW-1:0] c_level;

    always #5 clk = ~clk;

    cim_seq #(
        .HVDimension(D), .SeedWidth(SW), .NumCimLevels(N), .FlipsPerLevel(F)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .seed_hv_i(seed), .seed_valid_i(seed_valid), .seed_ready_o(seed_ready),
        .mode_i(mode),
        .req_level_i(req_level), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .cim_o(cim), .level_o(level)
    );

    cim_seq #(
        .HVDimension(D), .SeedWidth(SW), .NumCimLevels(NC), .FlipsPerLevel(F)
    ) dut_c (
        .clk_i(clk), .rst_i(rst),
        .seed_hv_i(seed), .seed_valid_i(c_seed_valid), .seed_ready_o(c_seed_ready),
        .mode_i(1'b0),
        .req_level_i(c_req_level), .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
        .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready),
        .cim_o(c_cim), .level_o(c_level)
    );

    typedef struct {
        int           lvl;
        logic [D-1:0] hv;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [D-1:0] m_base;
    int           m_level;
    logic         m_circ;
    logic [D-1:0] last_hv;

    function automatic logic [D-1:0] ref_base(input logic [SW-1:0] s);
        logic [D-1:0] hv;
        int w, l, r;
        hv = '0;
        for (int i = 0; i < SW; i++) hv[i] = s[i];
        w = SW;
        while (w < D) begin
            for (int i = 0; i < w; i++) begin
                l = (i == 0) ? w - 1 : i - 1;
                r = (i == w - 1) ? 0 : i + 1;
                hv[w + i] = hv[l] ^ hv[r];
            end
            w = w * 2;
        end
        return hv;
    endfunction

    function automatic logic [D-1:0] grp_mask(input int g);
        logic [D-1:0] m;
        m = '0;
        for (int j = 0; j < F; j++) m[2 * (g * F + j) + 1] = 1'b1;
        return m;
    endfunction

    function automatic logic [D-1:0] ref_hv(input logic [D-1:0] b, input int lv,
                                            input logic circ, input int n);
        logic [D-1:0] hv;
        hv = b;
        if (circ && lv > n / 2) begin
            for (int g = lv - n / 2; g < n / 2; g++) hv = hv ^ grp_mask(g);
        end else begin
            for (int g = 0; g < lv; g++) hv = hv ^ grp_mask(g);
        end
        return hv;
    endfunction

    function automatic int ref_dist(input int cur, input int tg,
                                    input logic circ, input int n);
        int u, dn;
        if (!circ) return (tg > cur) ? tg - cur : cur - tg;
        u  = (tg - cur + n) % n;
        dn = (cur - tg + n) % n;
        return (u <= dn) ? u : dn;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [SW-1:0] s, input logic md);
        seed       = s;
        mode       = md;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        m_base  = ref_base(s);
        m_level = 0;
`ifdef CIM_SEQ_CIRCULAR_EN
        m_circ = md;
`else
        m_circ = 1'b0;
`endif
        checks++;
        if (cim !== m_base) begin
            errors++;
            $display("FAIL seed_cim got=%h want=%h", cim, m_base);
        end
        checks++;
        if (level !== '0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_level got=%0d/%b want=0/0", level, rsp_valid);
        end
    endtask

    task automatic issue_req(input int lv, input int ham);
        int   tg, d, cyc;
        exp_t e;
        tg = (lv >= N) ? N - 1 : lv;
        d  = ref_dist(m_level, tg, m_circ, N);
        sb.push_back('{tg, ref_hv(m_base, tg, m_circ, N), 1 + d});
        m_level   = tg;
        req_level = LW'(lv);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        e = sb.pop_front();
        last_hv = e.hv;
        checks++;
        if (rsp_valid !== 1'b1 || cyc !== e.lat) begin
            errors++;
            $display("FAIL req%0d_latency got=%0d valid=%b want=%0d", lv, cyc, rsp_valid, e.lat);
        end
        checks++;
        if (32'(level) !== e.lvl) begin
            errors++;
            $display("FAIL req%0d_level got=%0d want=%0d", lv, level, e.lvl);
        end
        checks++;
        if (cim !== e.hv) begin
            errors++;
            $display("FAIL req%0d_cim got=%h want=%h", lv, cim, e.hv);
        end
        checks++;
        if ($countones(cim ^ m_base) !== ham) begin
            errors++;
            $display("FAIL req%0d_hamming got=%0d want=%0d", lv, $countones(cim ^ m_base), ham);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || seed_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_done got=%b%b%b want=011", rsp_valid, req_ready, seed_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cim !== '0 || level !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b/%0d/%0d want=0/0/0", rsp_valid, $countones(cim), level);
        end
        checks++;
        if (seed_ready !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b%b want=11", seed_ready, req_ready);
        end
    endtask

    task automatic test_level0();
        load_seed(32'h1234_5678, 1'b0);
        checks++;
        if (cim[SW-1:0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL base_low got=%h want=12345678", cim[SW-1:0]);
        end
        issue_req(0, 0);
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        issue_req(5, 20);
        finish_rsp();
        issue_req(2, 8);
        finish_rsp();
    endtask

    task automatic test_hold();
        issue_req(63, 252);
        seed_valid = 1'b1;
        req_valid  = 1'b1;
        req_level  = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || cim !== last_hv || level !== 6'd63) begin
                errors++;
                $display("FAIL hold_out cyc=%0d got=%b/%0d want=1/63", i, rsp_valid, level);
            end
            checks++;
            if (req_ready !== 1'b0 || seed_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready cyc=%0d got=%b%b want=00", i, req_ready, seed_ready);
            end
        end
        seed_valid = 1'b0;
        req_valid  = 1'b0;
        finish_rsp();
    endtask

    task automatic test_seed_priority();
        seed       = 32'h0BAD_BEEF;
        mode       = 1'b0;
        seed_valid = 1'b1;
        req_valid  = 1'b1;
        req_level  = 6'd3;
        tick();
        seed_valid = 1'b0;
        m_base  = ref_base(32'h0BAD_BEEF);
        m_level = 0;
        m_circ  = 1'b0;
        checks++;
        if (cim !== m_base || level !== '0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_priority got=%0d/%b want=0/0", level, rsp_valid);
        end
        issue_req(3, 12);
        finish_rsp();
    endtask

`ifdef CIM_SEQ_CIRCULAR_EN
    task automatic test_mode();
        logic [D-1:0] want;
        load_seed(32'h1234_5678, 1'b1);
        issue_req(32, 128);
        finish_rsp();
        load_seed(32'h1234_5678, 1'b1);
        issue_req(63, 4);
        want = m_base;
        want[249] = ~want[249];
        want[251] = ~want[251];
        want[253] = ~want[253];
        want[255] = ~want[255];
        checks++;
        if (cim !== want) begin
            errors++;
            $display("FAIL circ_wrap got=%h want=%h", cim, want);
        end
        finish_rsp();
    endtask
`else
    task automatic test_mode();
        load_seed(32'h1234_5678, 1'b1);
        issue_req(33, 132);
        finish_rsp();
    endtask
`endif

    task automatic test_reset_mid();
        load_seed(32'h1234_5678, 1'b0);
        req_level = 6'd40;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cim !== '0 || level !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%0d/%0d want=0/0/0", rsp_valid, $countones(cim), level);
        end
        checks++;
        if (seed_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready got=%b want=1", seed_ready);
        end
        load_seed(32'h5555_AAAA, 1'b0);
        issue_req(7, 28);
        finish_rsp();
    endtask

    task automatic test_clamp();
        exp_t         e;
        logic [D-1:0] b;
        int           cyc;
        b = ref_base(32'hCAFE_F00D);
        seed         = 32'hCAFE_F00D;
        c_seed_valid = 1'b1;
        tick();
        c_seed_valid = 1'b0;
        checks++;
        if (c_cim !== b) begin
            errors++;
            $display("FAIL clamp_seed got=%h want=%h", c_cim, b);
        end
        sb.push_back('{NC - 1, ref_hv(b, NC - 1, 1'b0, NC), NC});
        c_req_level = 6'd50;
        c_req_valid = 1'b1;
        tick();
        c_req_valid = 1'b0;
        cyc = 1;
        while (!c_rsp_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (c_rsp_valid !== 1'b1 || cyc !== e.lat || 32'(c_level) !== e.lvl) begin
            errors++;
            $display("FAIL clamp_rsp got=%0d/%0d want=%0d/%0d", cyc, c_level, e.lat, e.lvl);
        end
        checks++;
        if (c_cim !== e.hv || $countones(c_cim ^ b) !== 156) begin
            errors++;
            $display("FAIL clamp_cim ham=%0d want=156", $countones(c_cim ^ b));
        end
        c_rsp_ready = 1'b1;
        tick();
        c_rsp_ready = 1'b0;
        checks++;
        if (c_rsp_valid !== 1'b0 || c_req_ready !== 1'b1 || c_seed_ready !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done got=%b%b%b want=011", c_rsp_valid, c_req_ready, c_seed_ready);
        end
    endtask

    initial begin
        rst          = 1'b1;
        seed         = '0;
        seed_valid   = 1'b0;
        mode         = 1'b0;
        req_level    = '0;
        req_valid    = 1'b0;
        rsp_ready    = 1'b0;
        c_seed_valid = 1'b0;
        c_req_level  = '0;
        c_req_valid  = 1'b0;
        c_rsp_ready  = 1'b0;
        m_base       = '0;
        m_level      = 0;
        m_circ       = 1'b0;
        last_hv      = '0;
        test_reset();
        test_level0();
        test_back_to_back();
        test_hold();
        test_seed_priority();
        test_mode();
        test_reset_mid();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
